// File: rtl/cell5_bist_engine_pkg.sv
// cell_bist_pkg: FSM states, signature defaults and pattern-bit-to-pin map for the cell BIST engine
package cell_bist_pkg;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_APPLY  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_SAMPLE = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;
  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    APPLY  = ST_APPLY,
    WAIT   = ST_WAIT,
    SAMPLE = ST_SAMPLE,
    FINISH = ST_FINISH
  } state_t;
  localparam logic [15:0] DEF_POLY = 16'h1021;
  localparam logic [15:0] DEF_SEED = 16'hFFFF;
  localparam int PIN_IN1 = 0;
  localparam int PIN_IN2 = 1;
  localparam int PIN_IN3 = 2;
  localparam int PIN_IN4 = 3;
  localparam int PIN_IN5 = 4;
endpackage

// File: rtl/cell5_bist_engine_misr.sv
// bist_misr: serial signature register, shift-left with polynomial feedback on (msb ^ din)
module bist_misr
  import cell_bist_pkg::*;
#(
  parameter int SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY = DEF_POLY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic             din,
  input  logic [SIG_W-1:0] seed,
  output logic [SIG_W-1:0] sig
);
  always_ff @(posedge clk or posedge rst)
    if (rst) sig <= seed;
    else if (load) sig <= seed;
    else if (en) sig <= {sig[SIG_W-2:0], 1'b0} ^ ((sig[SIG_W-1] ^ din) ? POLY : '0);
endmodule

// File: rtl/cell5_bist_engine.sv
// cell5_bist_engine: exhaustive pattern generator for a 5-input cell with signature/ones-count compaction and pass/fail
module cell5_bist_engine
  import cell_bist_pkg::*;
#(
  parameter int NIN = 5,
  parameter int SETTLE = 2,
  parameter int SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY = DEF_POLY,
  parameter logic [SIG_W-1:0] SEED = DEF_SEED,
  parameter logic [SIG_W-1:0] EXP_SIG = '0,
  parameter int EXP_ONES = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             qn_obs,
  output logic [NIN-1:0]   pat,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] sig,
  output logic [NIN:0]     ones
);
  localparam logic [3:0] WLOAD = 4'(SETTLE > 0 ? SETTLE - 1 : 0);
  logic [2:0] state;
  logic [3:0] wcnt;
  logic [SIG_W-1:0] sig_nx;
  logic [NIN:0] ones_nx;
  // PASS must see the final sample, so compare against the values about to be written
  always_comb begin
    sig_nx = {sig[SIG_W-2:0], 1'b0} ^ ((sig[SIG_W-1] ^ qn_obs) ? POLY : '0);
    ones_nx = ones + (NIN+1)'(qn_obs);
    busy = state == ST_APPLY || state == ST_WAIT || state == ST_SAMPLE;
    done = state == ST_FINISH;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      pat <= '0;
      wcnt <= '0;
      ones <= '0;
      pass <= 1'b0;
    end else begin
      case (state)
        ST_IDLE:
          if (start) begin
            state <= ST_APPLY;
            pat <= '0;
            ones <= '0;
            pass <= 1'b0;
          end
        ST_APPLY: begin
          state <= (SETTLE == 0) ? ST_SAMPLE : ST_WAIT;
          wcnt <= WLOAD;
        end
        ST_WAIT:
          if (wcnt == '0) state <= ST_SAMPLE;
          else wcnt <= wcnt - 4'd1;
        ST_SAMPLE: begin
          ones <= ones_nx;
          if (&pat) begin
            state <= ST_FINISH;
            pass <= sig_nx == EXP_SIG && ones_nx == (NIN+1)'(EXP_ONES);
          end else begin
            state <= ST_APPLY;
            pat <= pat + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  bist_misr #(.SIG_W(SIG_W), .POLY(POLY)) u_misr (
    .clk(clk),
    .rst(rst),
    .load(state == ST_IDLE && start),
    .en(state == ST_SAMPLE),
    .din(qn_obs),
    .seed(SEED),
    .sig(sig)
  );
endmodule

// File: tb/tb_cell5_bist_engine.sv
// tb_cell5_bist_engine: randomized runs of the BIST engine against a truth-table/CRC reference model
module tb_cell5_bist_engine;
  import cell_bist_pkg::*;

  function automatic logic [31:0] aoi_tt();
    logic [31:0] t;
    logic [4:0] p;
    t = '0;
    for (int i = 0; i < 32; i++) begin
      p = 5'(i);
      t[i] = !((p[PIN_IN1] & p[PIN_IN2]) | (p[PIN_IN3] & p[PIN_IN4]) | p[PIN_IN5]);
    end
    return t;
  endfunction

  function automatic logic [15:0] model_sig(input logic [31:0] t);
    logic [15:0] s;
    s = 16'hFFFF;
    for (int i = 0; i < 32; i++) s = (s[15] ^ t[i]) ? ((s << 1) ^ 16'h1021) : (s << 1);
    return s;
  endfunction

  function automatic int settle_of(input int w);
    return w == 0 ? 2 : (w == 1 ? 0 : 15);
  endfunction

  localparam logic [31:0] AOI_TT = aoi_tt();
  localparam logic [15:0] GOLD = model_sig(AOI_TT);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] tt = '0;
  logic start_a[3];
  logic qn_a[3];
  logic [4:0] pat_a[3];
  logic busy_a[3], done_a[3], pass_a[3];
  logic [15:0] sig_a[3];
  logic [5:0] ones_a[3];
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  assign qn_a[0] = tt[pat_a[0]];
  assign qn_a[1] = tt[pat_a[1]];
  assign qn_a[2] = tt[pat_a[2]];

  cell5_bist_engine #(.SETTLE(2), .EXP_SIG(GOLD), .EXP_ONES(9)) dut (
    .clk(clk), .rst(rst), .start(start_a[0]), .qn_obs(qn_a[0]), .pat(pat_a[0]), .busy(busy_a[0]),
    .done(done_a[0]), .pass(pass_a[0]), .sig(sig_a[0]), .ones(ones_a[0]));
  cell5_bist_engine #(.SETTLE(0), .EXP_SIG(GOLD), .EXP_ONES(9)) dut0 (
    .clk(clk), .rst(rst), .start(start_a[1]), .qn_obs(qn_a[1]), .pat(pat_a[1]), .busy(busy_a[1]),
    .done(done_a[1]), .pass(pass_a[1]), .sig(sig_a[1]), .ones(ones_a[1]));
  cell5_bist_engine #(.SETTLE(15), .EXP_SIG(GOLD), .EXP_ONES(9)) dut15 (
    .clk(clk), .rst(rst), .start(start_a[2]), .qn_obs(qn_a[2]), .pat(pat_a[2]), .busy(busy_a[2]),
    .done(done_a[2]), .pass(pass_a[2]), .sig(sig_a[2]), .ones(ones_a[2]));

  // Drives one run and reports when DONE appeared (cycle k lies between START edge+k-1 and +k)
  task automatic do_run(input int w, input logic [31:0] t, output int dcyc, output bit seq_ok,
                        output logic [15:0] s, output logic [5:0] o, output logic p, output logic b);
    int st;
    logic [15:0] prev;
    st = settle_of(w);
    tt = t;
    dcyc = -1;
    seq_ok = 1'b1;
    s = 'x; o = 'x; p = 'x; b = 'x;
    prev = 'x;
    repeat ($urandom_range(0, 4)) @(negedge clk);
    @(negedge clk) start_a[w] = 1'b1;
    @(posedge clk);
    #1 start_a[w] = 1'b0;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk);
      if (done_a[w] === 1'b1) begin
        dcyc = k; s = sig_a[w]; o = ones_a[w]; p = pass_a[w]; b = busy_a[w];
        break;
      end
      if (busy_a[w] !== 1'b1 || pat_a[w] !== 5'((k - 1) / (st + 2))) seq_ok = 1'b0;
      if (k == 1) begin
        if (sig_a[w] !== 16'hFFFF || ones_a[w] !== 6'd0) seq_ok = 1'b0;
      end else if (sig_a[w] !== prev && (k - 2) % (st + 2) != st + 1) seq_ok = 1'b0;
      prev = sig_a[w];
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #12;
    n_cmp++; if (pat_a[0] !== 5'd0) begin n_fail++; $display("FAIL reset_pat: got %0h want 0", pat_a[0]); end
    n_cmp++; if (busy_a[0] !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy_a[0]); end
    n_cmp++; if (done_a[0] !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", done_a[0]); end
    n_cmp++; if (pass_a[0] !== 1'b0) begin n_fail++; $display("FAIL reset_pass: got %0b want 0", pass_a[0]); end
    n_cmp++; if (sig_a[0] !== 16'hFFFF) begin n_fail++; $display("FAIL reset_sig: got %h want ffff", sig_a[0]); end
    n_cmp++; if (ones_a[0] !== 6'd0) begin n_fail++; $display("FAIL reset_ones: got %0d want 0", ones_a[0]); end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_aoi221;
    int d; bit ok; logic [15:0] s; logic [5:0] o; logic p, b;
    do_run(0, AOI_TT, d, ok, s, o, p, b);
    n_cmp++; if (d !== 129) begin n_fail++; $display("FAIL aoi_done_cycle: got %0d want 129", d); end
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL aoi_sequence: got bad pat/busy/sig stepping want clean"); end
    n_cmp++; if (o !== 6'd9) begin n_fail++; $display("FAIL aoi_ones: got %0d want 9", o); end
    n_cmp++; if (s !== GOLD) begin n_fail++; $display("FAIL aoi_sig: got %h want %h", s, GOLD); end
    n_cmp++; if (p !== 1'b1) begin n_fail++; $display("FAIL aoi_pass: got %0b want 1", p); end
    n_cmp++; if (b !== 1'b0) begin n_fail++; $display("FAIL aoi_busy_at_done: got %0b want 0", b); end
    n_cmp++; if (pass_a[0] !== 1'b1 || pat_a[0] !== 5'd31) begin
      n_fail++; $display("FAIL aoi_hold: got pass=%0b pat=%0d want 1/31", pass_a[0], pat_a[0]); end
  endtask

  task automatic test_stuck;
    int d; bit ok; logic [15:0] s; logic [5:0] o; logic p, b;
    do_run(0, 32'h0, d, ok, s, o, p, b);
    n_cmp++; if (o !== 6'd0) begin n_fail++; $display("FAIL sa0_ones: got %0d want 0", o); end
    n_cmp++; if (s !== model_sig(32'h0)) begin n_fail++; $display("FAIL sa0_sig: got %h want %h", s, model_sig(32'h0)); end
    n_cmp++; if (p !== 1'b0) begin n_fail++; $display("FAIL sa0_pass: got %0b want 0", p); end
    do_run(0, 32'hFFFF_FFFF, d, ok, s, o, p, b);
    n_cmp++; if (o !== 6'd32) begin n_fail++; $display("FAIL sa1_ones: got %0d want 32", o); end
    n_cmp++; if (s !== model_sig(32'hFFFF_FFFF)) begin
      n_fail++; $display("FAIL sa1_sig: got %h want %h", s, model_sig(32'hFFFF_FFFF)); end
    n_cmp++; if (p !== 1'b0) begin n_fail++; $display("FAIL sa1_pass: got %0b want 0", p); end
  endtask

  task automatic test_settle;
    int d; bit ok; logic [15:0] s; logic [5:0] o; logic p, b;
    do_run(1, AOI_TT, d, ok, s, o, p, b);
    n_cmp++; if (d !== 65) begin n_fail++; $display("FAIL settle0_done_cycle: got %0d want 65", d); end
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL settle0_sequence: got bad stepping want clean"); end
    n_cmp++; if (s !== GOLD || p !== 1'b1) begin n_fail++; $display("FAIL settle0_result: got %h/%0b want %h/1", s, p, GOLD); end
    do_run(2, AOI_TT, d, ok, s, o, p, b);
    n_cmp++; if (d !== 545) begin n_fail++; $display("FAIL settle15_done_cycle: got %0d want 545", d); end
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL settle15_sequence: got bad stepping want clean"); end
    n_cmp++; if (o !== 6'd9) begin n_fail++; $display("FAIL settle15_ones: got %0d want 9", o); end
  endtask

  task automatic test_back_to_back;
    int d1, d2, extra;
    logic b130, b131;
    logic [4:0] p130, p131;
    d1 = -1; d2 = -1; extra = 0;
    b130 = 'x; b131 = 'x; p130 = 'x; p131 = 'x;
    tt = AOI_TT;
    @(negedge clk) start_a[0] = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (done_a[0] === 1'b1) begin
        if (d1 < 0) d1 = k;
        else if (d2 < 0) d2 = k;
        else extra++;
      end
      if (k == 130) begin b130 = busy_a[0]; p130 = pat_a[0]; end
      if (k == 131) begin b131 = busy_a[0]; p131 = pat_a[0]; end
      if (k == 150) start_a[0] = 1'b0;
    end
    n_cmp++; if (d1 !== 129) begin n_fail++; $display("FAIL b2b_first_done: got %0d want 129", d1); end
    n_cmp++; if (d2 !== 259) begin n_fail++; $display("FAIL b2b_second_done: got %0d want 259", d2); end
    n_cmp++; if (extra !== 0) begin n_fail++; $display("FAIL b2b_extra_runs: got %0d want 0", extra); end
    n_cmp++; if (b130 !== 1'b0 || p130 !== 5'd31) begin
      n_fail++; $display("FAIL b2b_idle_gap: got busy=%0b pat=%0d want 0/31", b130, p130); end
    n_cmp++; if (b131 !== 1'b1 || p131 !== 5'd0) begin
      n_fail++; $display("FAIL b2b_restart: got busy=%0b pat=%0d want 1/0", b131, p131); end
  endtask

  task automatic test_reset_mid_run;
    int k, nd, d; bit ok; logic [15:0] s; logic [5:0] o; logic p, b;
    tt = AOI_TT;
    @(negedge clk) start_a[0] = 1'b1;
    @(posedge clk);
    #1 start_a[0] = 1'b0;
    k = 0;
    while (pat_a[0] !== 5'd17 && k < 2000) begin @(negedge clk); k++; end
    n_cmp++; if (pat_a[0] !== 5'd17) begin n_fail++; $display("FAIL rst_reach_p17: got %0d want 17", pat_a[0]); end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (busy_a[0] !== 1'b0 || done_a[0] !== 1'b0 || pass_a[0] !== 1'b0) begin
      n_fail++; $display("FAIL rst_async_flags: got busy=%0b done=%0b pass=%0b want 0/0/0", busy_a[0], done_a[0], pass_a[0]); end
    n_cmp++; if (pat_a[0] !== 5'd0 || ones_a[0] !== 6'd0) begin
      n_fail++; $display("FAIL rst_async_pat_ones: got %0d/%0d want 0/0", pat_a[0], ones_a[0]); end
    n_cmp++; if (sig_a[0] !== 16'hFFFF) begin n_fail++; $display("FAIL rst_async_sig: got %h want ffff", sig_a[0]); end
    @(negedge clk) rst = 1'b0;
    nd = 0;
    repeat (600) begin
      @(negedge clk);
      if (done_a[0] !== 1'b0 || busy_a[0] !== 1'b0) nd++;
    end
    n_cmp++; if (nd !== 0) begin n_fail++; $display("FAIL rst_no_done: got %0d active cycles want 0", nd); end
    do_run(0, AOI_TT, d, ok, s, o, p, b);
    n_cmp++; if (s !== GOLD || d !== 129) begin n_fail++; $display("FAIL rst_rerun: got %h@%0d want %h@129", s, d, GOLD); end
  endtask

  task automatic test_single_fault;
    int d; bit ok; logic [15:0] s; logic [5:0] o; logic p, b;
    logic [31:0] t;
    t = AOI_TT ^ 32'h0000_0008;
    do_run(0, t, d, ok, s, o, p, b);
    n_cmp++; if (o !== 6'd10) begin n_fail++; $display("FAIL fault_ones: got %0d want 10", o); end
    n_cmp++; if (s !== model_sig(t)) begin n_fail++; $display("FAIL fault_sig: got %h want %h", s, model_sig(t)); end
    n_cmp++; if (s === GOLD) begin n_fail++; $display("FAIL fault_sig_differs: got %h want not %h", s, GOLD); end
    n_cmp++; if (p !== 1'b0) begin n_fail++; $display("FAIL fault_pass: got %0b want 0", p); end
  endtask

  task automatic test_random;
    int d; bit ok; logic [15:0] s, m; logic [5:0] o; logic p, b;
    logic [31:0] t;
    for (int i = 0; i < 4; i++) begin
      t = $urandom;
      m = model_sig(t);
      do_run(0, t, d, ok, s, o, p, b);
      n_cmp++; if (s !== m) begin n_fail++; $display("FAIL rand_sig[%0d]: got %h want %h (tt %h)", i, s, m, t); end
      n_cmp++; if (o !== 6'($countones(t))) begin
        n_fail++; $display("FAIL rand_ones[%0d]: got %0d want %0d", i, o, $countones(t)); end
      n_cmp++; if (p !== (m == GOLD && $countones(t) == 9)) begin
        n_fail++; $display("FAIL rand_pass[%0d]: got %0b want %0b", i, p, m == GOLD && $countones(t) == 9); end
      n_cmp++; if (d !== 129 || !ok) begin n_fail++; $display("FAIL rand_timing[%0d]: got %0d ok=%0b want 129 ok=1", i, d, ok); end
    end
  endtask

  initial begin
    start_a[0] = 1'b0;
    start_a[1] = 1'b0;
    start_a[2] = 1'b0;
    test_reset();
    test_aoi221();
    test_stuck();
    test_settle();
    test_back_to_back();
    test_reset_mid_run();
    test_single_fault();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish before 500000");
    $fatal(1);
  end
endmodule
